// File: rtl/drlp_master_layer_sequencer_if.sv
// Command and DRLP-array signal bundle for the master layer sequencer.
// The master modport is the sequencer's view. The slave modport is the view of the processor and the array.
interface drlp_master_layer_sequencer_if #(
  parameter int imem_addr_width_p = 13,
  parameter int num_pe_p          = 16
);
  logic                         cmd_v_i;
  logic                         cmd_ready_o;
  logic [imem_addr_width_p-1:0] cmd_base_addr_i;
  logic [imem_addr_width_p-1:0] cmd_len_i;
  logic [num_pe_p-1:0]          cmd_pe_mask_i;
  logic                         cmd_dw_i;
  logic                         all_pe_ready_i;
  logic                         all_slave_done_i;
  logic [num_pe_p-1:0]          pe_data_v_o;
  logic [imem_addr_width_p-1:0] imem_r_addr_o;
  logic                         sld_o;
  logic                         dw_wgt_start_o;
  logic                         busy_o;
  logic                         done_o;
  logic                         error_o;

  modport master (
    input  cmd_v_i, cmd_base_addr_i, cmd_len_i, cmd_pe_mask_i, cmd_dw_i,
           all_pe_ready_i, all_slave_done_i,
    output cmd_ready_o, pe_data_v_o, imem_r_addr_o, sld_o, dw_wgt_start_o,
           busy_o, done_o, error_o
  );

  modport slave (
    output cmd_v_i, cmd_base_addr_i, cmd_len_i, cmd_pe_mask_i, cmd_dw_i,
           all_pe_ready_i, all_slave_done_i,
    input  cmd_ready_o, pe_data_v_o, imem_r_addr_o, sld_o, dw_wgt_start_o,
           busy_o, done_o, error_o
  );
endinterface

// File: rtl/drlp_master_layer_sequencer.sv
// Sequences one DRLP layer pass: optional weight-start pulse, row streaming, drain, then a done pulse.
// Define DRLP_SEQ_TIMEOUT_EN to add a drain timeout that drives error_o.
module drlp_master_layer_sequencer #(
  parameter int imem_addr_width_p = 13,
  parameter int num_pe_p          = 16,
  parameter int timeout_p         = 1024
) (
  input logic clk_i,
  input logic reset_i,
  drlp_master_layer_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, WGT, STREAM, DRAIN, DONE} state_e;

  state_e                       state;
  logic [imem_addr_width_p-1:0] addr_r;
  logic [imem_addr_width_p-1:0] rem_r;
  logic [num_pe_p-1:0]          mask_r;
  logic                         error_r;

`ifdef DRLP_SEQ_TIMEOUT_EN
  localparam int cnt_w = (timeout_p > 2) ? $clog2(timeout_p) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(timeout_p - 1);
  logic [cnt_w-1:0] drain_cnt;
`else
  localparam int unused_timeout = timeout_p;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      addr_r  <= '0;
      rem_r   <= '0;
      mask_r  <= '0;
      error_r <= 1'b0;
`ifdef DRLP_SEQ_TIMEOUT_EN
      drain_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_v_i) begin
            addr_r  <= bus.cmd_base_addr_i;
            rem_r   <= bus.cmd_len_i;
            mask_r  <= bus.cmd_pe_mask_i;
            error_r <= 1'b0;
            if (bus.cmd_len_i == '0)
              state <= DONE;
            else if (bus.cmd_dw_i)
              state <= WGT;
            else
              state <= STREAM;
          end
        end
        WGT: state <= STREAM;
        STREAM: begin
          if (bus.all_pe_ready_i) begin
            addr_r <= addr_r + 1'b1;
            rem_r  <= rem_r - 1'b1;
            if (rem_r == imem_addr_width_p'(1)) begin
              state <= DRAIN;
`ifdef DRLP_SEQ_TIMEOUT_EN
              drain_cnt <= '0;
`endif
            end
          end
        end
        DRAIN: begin
          // A slave-done on the last counted cycle wins over the timeout.
          if (bus.all_slave_done_i)
            state <= DONE;
`ifdef DRLP_SEQ_TIMEOUT_EN
          else if (drain_cnt == cnt_last) begin
            state   <= DONE;
            error_r <= 1'b1;
          end else
            drain_cnt <= drain_cnt + 1'b1;
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Only the lane valids and last-row marker see all_pe_ready_i combinationally.
  assign bus.pe_data_v_o    = (state == STREAM && bus.all_pe_ready_i) ? mask_r : '0;
  assign bus.sld_o          = (state == STREAM) && bus.all_pe_ready_i &&
                              (rem_r == imem_addr_width_p'(1));
  assign bus.imem_r_addr_o  = addr_r;
  assign bus.cmd_ready_o    = (state == IDLE);
  assign bus.busy_o         = (state != IDLE);
  assign bus.dw_wgt_start_o = (state == WGT);
  assign bus.done_o         = (state == DONE);
  assign bus.error_o        = error_r;

endmodule

// File: doc/drlp_master_layer_sequencer.md
Name: drlp_master_layer_sequencer

Overview:
- Sequences one DRLP layer pass for the DRLP master tile.
- Accepts a layer command from the manycore processor side: IMEM base address, row count, PE mask and depthwise flag.
- Drives the DRLP array strobes (pe_data_v, imem_r_addr, sld, dw_wgt_start), using all_pe_ready for flow control and all_slave_done for completion.
- Returns a done pulse to the processor.

Parameters:
- imem_addr_width_p, 13, width of IMEM read address and row counter
- num_pe_p, 16, number of PE data-valid lanes
- timeout_p, 1024, cycle limit in DRAIN; used only with DRLP_SEQ_TIMEOUT_EN

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- cmd_v_i  in  1  command valid
- cmd_ready_o  out  1  command accept; high only in IDLE
- cmd_base_addr_i  in  imem_addr_width_p  first IMEM row address
- cmd_len_i  in  imem_addr_width_p  number of rows to stream; 0 is legal
- cmd_pe_mask_i  in  num_pe_p  lanes driven during streaming
- cmd_dw_i  in  1  depthwise layer; issue a weight-start pulse first
- all_pe_ready_i  in  1  array can accept a row this cycle
- all_slave_done_i  in  1  all slaves have finished the pass
- pe_data_v_o  out  num_pe_p  per-lane row valid
- imem_r_addr_o  out  imem_addr_width_p  IMEM row address
- sld_o  out  1  last-row marker
- dw_wgt_start_o  out  1  depthwise weight-load start pulse
- busy_o  out  1  not in IDLE
- done_o  out  1  one-cycle completion pulse
- error_o  out  1  timeout flag; see Optional Feature

Behaviour:
- Reset values: all outputs 0 except cmd_ready_o=1. State=IDLE, counters=0.
- A reset asserted mid-operation aborts the pass in the same edge. No done_o is issued.
- All outputs are registered-state decodes with no combinational path from inputs to outputs, except pe_data_v_o and sld_o, which are gated by all_pe_ready_i.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_v_i&cmd_ready_o, latch base, len, mask and dw, and load addr_r=base, rem_r=len.
  - Next state: len==0 -> DONE; else dw=1 -> WGT; else STREAM.
- WGT: dw_wgt_start_o=1 for exactly this one cycle, then STREAM.
- STREAM:
  - imem_r_addr_o=addr_r. pe_data_v_o = all_pe_ready_i ? mask_r : 0.
  - sld_o = all_pe_ready_i & (rem_r==1).
  - On a ready cycle: addr_r+=1 modulo 2^imem_addr_width_p (wraps silently) and rem_r-=1. When rem_r==1 the next state is DRAIN.
  - When all_pe_ready_i=0: pe_data_v_o=0, sld_o=0, addr_r and rem_r hold. A stall may last any length.
  - A mask of all zeros still counts rows and still emits sld_o.
- DRAIN:
  - imem_r_addr_o holds its last value+1; pe_data_v_o=0.
  - Wait for all_slave_done_i=1, sampled from the first DRAIN cycle onward. A done level already high on entry completes immediately, giving a 1-cycle DRAIN.
  - Then DONE.
- DONE: done_o=1 for one cycle, then IDLE. cmd_ready_o=0 in DONE, so back-to-back commands have a 1-cycle gap.
- all_slave_done_i outside DRAIN is ignored.
- Latency for len=N, dw=0, ready always 1:
  - accept edge -> first pe_data_v at cycle 1;
  - N valid cycles, with sld_o on cycle N;
  - DRAIN ≥1 cycle;
  - done_o at cycle N+2 earliest.
- dw=1 adds one cycle.
- busy_o = (state!=IDLE).

Optional Feature:
- Macro: DRLP_SEQ_TIMEOUT_EN.
- Defined:
  - A counter clears on DRAIN entry and increments each DRAIN cycle.
  - If it reaches timeout_p-1 without all_slave_done_i, go to DONE. done_o pulses and error_o is set.
  - error_o stays 1 until the next command acceptance or reset.
  - all_slave_done_i on the final counted cycle takes priority: no error.
- Undefined: no counter is built, error_o is tied 0, and DRAIN waits indefinitely.

Test Plan:
- Basic pass: cmd base=0x100, len=4, mask=0xFFFF, dw=0; ready=1; slave_done 2 cycles after sld.
  - pe_data_v=0xFFFF for 4 cycles at addrs 0x100-0x103.
  - sld only with 0x103.
  - done_o 1 cycle; cmd_ready_o back to 1.
- Backpressure: len=3, mask=0x00F0; ready toggles 1,0,0,1,0,1.
  - Valid only on ready cycles at addrs base, base+1, base+2.
  - Addr holds during stalls; sld on third valid.
- Depthwise + wrap: base=0x1FFE, len=3, dw=1.
  - dw_wgt_start_o one pulse before streaming.
  - Addrs 0x1FFE, 0x1FFF, 0x0000; sld with 0x0000.
- Zero length: len=0 -> no pe_data_v, no sld, no dw pulse; done_o on the cycle after acceptance.
- Reset mid-stream: reset_i after 2 of 8 rows.
  - Next cycle all outputs 0 and cmd_ready_o=1; no done_o.
  - A new command then runs normally.
- Timeout (macro on, timeout_p=8): all_slave_done_i held 0 → done_o and error_o=1 after 8 DRAIN cycles; error_o clears on the next command acceptance.
